// File: rtl/cv32e40p_sleep_ctrl.sv
// rtl/cv32e40p_sleep_ctrl.sv - core clock-enable controller for WFI sleep and wake
// Gates the core clock only when the core is idle and both OBI buses are quiescent.
module cv32e40p_sleep_ctrl #(
   parameter int OUTST_W    = 2,
   parameter int WAKE_DELAY = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               fetch_enable_i,
   input  logic               wfi_i,
   input  logic               irq_pending_i,
   input  logic               debug_req_i,
   input  logic               instr_req_i,
   input  logic               instr_gnt_i,
   input  logic               instr_rvalid_i,
   input  logic               data_req_i,
   input  logic               data_gnt_i,
   input  logic               data_rvalid_i,
   output logic               clock_en_o,
   output logic               core_sleep_o,
   output logic               fetch_enable_o,
   output logic [OUTST_W-1:0] instr_outst_o,
   output logic [OUTST_W-1:0] data_outst_o
);

   localparam int WCW = (WAKE_DELAY < 2) ? 1 : $clog2(WAKE_DELAY + 1);
   localparam logic [OUTST_W-1:0] OUTST_MAX = {OUTST_W{1'b1}};

   typedef enum logic [2:0] {
      RESET_WAIT = 3'd0,
      RUN        = 3'd1,
      DRAIN      = 3'd2,
      SLEEP      = 3'd3,
      WAKE       = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WCW-1:0]   wake_cnt;
   logic [WCW-1:0]   wake_cnt_nxt;
   logic             wake;
   logic             idle;

   // Saturating up/down counter step; simultaneous inc/dec holds the value.
   function automatic logic [OUTST_W-1:0] outst_step(
      input logic [OUTST_W-1:0] cnt,
      input logic               inc,
      input logic               dec
   );
      logic [OUTST_W-1:0] res;
      res = cnt;
      if (inc && !dec && cnt != OUTST_MAX)
         res = cnt + 1'b1;
      else if (dec && !inc && cnt != '0)
         res = cnt - 1'b1;
      return res;
   endfunction

   assign wake = irq_pending_i | debug_req_i;
   assign idle = (instr_outst_o == '0) && (data_outst_o == '0) && !instr_req_i && !data_req_i;

   always_comb begin
      state_nxt    = state;
      wake_cnt_nxt = wake_cnt;
      case (state)
         RESET_WAIT: begin
            if (fetch_enable_i)
               state_nxt = RUN;
         end
         RUN: begin
            if (wfi_i && !wake)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (wake)
               state_nxt = RUN;
            else if (idle)
               state_nxt = SLEEP;
         end
         SLEEP: begin
            if (wake) begin
               if (WAKE_DELAY == 0) begin
                  state_nxt = RUN;
               end else begin
                  state_nxt    = WAKE;
                  wake_cnt_nxt = WCW'(WAKE_DELAY);
               end
            end
         end
         WAKE: begin
            // Once committed to waking, a dropped wake request does not abort.
            wake_cnt_nxt = wake_cnt - 1'b1;
            if (wake_cnt <= WCW'(1))
               state_nxt = RUN;
         end
         default: state_nxt = RESET_WAIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= RESET_WAIT;
         wake_cnt       <= '0;
         clock_en_o     <= 1'b0;
         core_sleep_o   <= 1'b0;
         fetch_enable_o <= 1'b0;
         instr_outst_o  <= '0;
         data_outst_o   <= '0;
      end else begin
         state        <= state_nxt;
         wake_cnt     <= wake_cnt_nxt;
         // Outputs decoded from the next state so they line up with the state itself.
         clock_en_o   <= (state_nxt == RUN) || (state_nxt == DRAIN) || (state_nxt == WAKE);
         core_sleep_o <= (state_nxt == SLEEP) || (state_nxt == WAKE);
         if (fetch_enable_i)
            fetch_enable_o <= 1'b1;
         instr_outst_o <= outst_step(instr_outst_o, instr_req_i & instr_gnt_i, instr_rvalid_i);
         data_outst_o  <= outst_step(data_outst_o, data_req_i & data_gnt_i, data_rvalid_i);
      end
   end

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// tb/tb_cv32e40p_sleep_ctrl.sv - directed scoreboard bench for cv32e40p_sleep_ctrl
module tb_cv32e40p_sleep_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       fe, wfi, irq, dbg;
   logic       ireq, ignt, irv, dreq, dgnt, drv;
   logic       clock_en, core_sleep, fetch_en_lat;
   logic [1:0] instr_outst, data_outst;

   typedef struct {
      string      tag;
      logic [6:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   cv32e40p_sleep_ctrl #(.OUTST_W(2), .WAKE_DELAY(2)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .fetch_enable_i (fe),
      .wfi_i          (wfi),
      .irq_pending_i  (irq),
      .debug_req_i    (dbg),
      .instr_req_i    (ireq),
      .instr_gnt_i    (ignt),
      .instr_rvalid_i (irv),
      .data_req_i     (dreq),
      .data_gnt_i     (dgnt),
      .data_rvalid_i  (drv),
      .clock_en_o     (clock_en),
      .core_sleep_o   (core_sleep),
      .fetch_enable_o (fetch_en_lat),
      .instr_outst_o  (instr_outst),
      .data_outst_o   (data_outst)
   );

   // One clock with the current inputs; expectation is {clock_en, core_sleep, fetch_en, instr_outst, data_outst}.
   task automatic cyc(input string tag, input logic ce, input logic cs, input logic fen,
                      input logic [1:0] io, input logic [1:0] dout);
      exp_t e;
      exp_t p;
      logic [6:0] obs;
      e.tag = tag;
      e.val = {ce, cs, fen, io, dout};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      p   = exp_q.pop_front();
      obs = {clock_en, core_sleep, fetch_en_lat, instr_outst, data_outst};
      n_cmp++;
      assert (obs === p.val) else begin
         n_fail++;
         $error("FAIL %s: observed ce/cs/fe/io/do=%b expected %b", p.tag, obs, p.val);
      end
   endtask

   initial begin
      rst = 1'b1; fe = 0; wfi = 0; irq = 0; dbg = 0;
      ireq = 0; ignt = 0; irv = 0; dreq = 0; dgnt = 0; drv = 0;
      cyc("reset", 0, 0, 0, 2'd0, 2'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cyc("reset_wait", 0, 0, 0, 2'd0, 2'd0);
      wfi = 1; cyc("wfi_ignored_in_reset_wait", 0, 0, 0, 2'd0, 2'd0); wfi = 0;
      fe = 1;  cyc("fetch_en_rise", 1, 0, 1, 2'd0, 2'd0);
      fe = 0;  cyc("fetch_en_drop", 1, 0, 1, 2'd0, 2'd0);

      // Two outstanding instruction fetches, then WFI drains them.
      ireq = 1; ignt = 1;
      cyc("instr_gnt1", 1, 0, 1, 2'd1, 2'd0);
      cyc("instr_gnt2", 1, 0, 1, 2'd2, 2'd0);
      ireq = 0; ignt = 0;
      wfi = 1; cyc("wfi_to_drain", 1, 0, 1, 2'd2, 2'd0); wfi = 0;
      irv = 1;
      cyc("drain_rvalid1", 1, 0, 1, 2'd1, 2'd0);
      cyc("drain_rvalid2", 1, 0, 1, 2'd0, 2'd0);
      irv = 0;
      cyc("drain_to_sleep", 0, 1, 1, 2'd0, 2'd0);
      wfi = 1; cyc("wfi_ignored_in_sleep", 0, 1, 1, 2'd0, 2'd0); wfi = 0;

      // Wake with delay 2; wake drops mid-WAKE without aborting.
      irq = 1; cyc("wake_first", 1, 1, 1, 2'd0, 2'd0);
      irq = 0; cyc("wake_second", 1, 1, 1, 2'd0, 2'd0);
      cyc("wake_to_run", 1, 0, 1, 2'd0, 2'd0);
      irq = 1; wfi = 1; cyc("wfi_with_wake_stays_run", 1, 0, 1, 2'd0, 2'd0);
      irq = 0; wfi = 0; cyc("run_idle", 1, 0, 1, 2'd0, 2'd0);

      // Drain aborted by debug request.
      dreq = 1; dgnt = 1; cyc("data_gnt", 1, 0, 1, 2'd0, 2'd1);
      dreq = 0; dgnt = 0;
      wfi = 1; cyc("wfi_drain_data", 1, 0, 1, 2'd0, 2'd1); wfi = 0;
      dbg = 1; cyc("debug_abort", 1, 0, 1, 2'd0, 2'd1); dbg = 0;
      drv = 1; cyc("abort_rvalid", 1, 0, 1, 2'd0, 2'd0); drv = 0;
      cyc("abort_stays_run", 1, 0, 1, 2'd0, 2'd0);

      // Grant in the cycle DRAIN would otherwise be idle.
      wfi = 1; cyc("wfi_drain2", 1, 0, 1, 2'd0, 2'd0); wfi = 0;
      dreq = 1; dgnt = 1; cyc("gnt_blocks_idle", 1, 0, 1, 2'd0, 2'd1);
      dreq = 0; dgnt = 0; cyc("drain_wait", 1, 0, 1, 2'd0, 2'd1);
      drv = 1; cyc("drain_rvalid", 1, 0, 1, 2'd0, 2'd0); drv = 0;
      cyc("drain_to_sleep2", 0, 1, 1, 2'd0, 2'd0);

      // Counters run during SLEEP; reset during WAKE clears everything.
      dreq = 1; dgnt = 1; cyc("sleep_counter", 0, 1, 1, 2'd0, 2'd1);
      dreq = 0; dgnt = 0;
      irq = 1; cyc("wake_again", 1, 1, 1, 2'd0, 2'd1);
      rst = 1; irq = 0; cyc("reset_in_wake", 0, 0, 0, 2'd0, 2'd0);
      rst = 0; cyc("after_reset", 0, 0, 0, 2'd0, 2'd0);

      // Saturation, simultaneous inc/dec, underflow guard.
      fe = 1; cyc("refetch", 1, 0, 1, 2'd0, 2'd0); fe = 0;
      dreq = 1; dgnt = 1;
      cyc("sat1", 1, 0, 1, 2'd0, 2'd1);
      cyc("sat2", 1, 0, 1, 2'd0, 2'd2);
      cyc("sat3", 1, 0, 1, 2'd0, 2'd3);
      cyc("sat_hold", 1, 0, 1, 2'd0, 2'd3);
      drv = 1; cyc("inc_dec_hold", 1, 0, 1, 2'd0, 2'd3);
      dreq = 0; dgnt = 0;
      cyc("dec1", 1, 0, 1, 2'd0, 2'd2);
      cyc("dec2", 1, 0, 1, 2'd0, 2'd1);
      cyc("dec3", 1, 0, 1, 2'd0, 2'd0);
      cyc("no_underflow", 1, 0, 1, 2'd0, 2'd0);
      irv = 1; cyc("instr_no_underflow", 1, 0, 1, 2'd0, 2'd0);
      irv = 0; drv = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cv32e40p_sleep_ctrl.md
Name: cv32e40p_sleep_ctrl

Overview:
- Generates the clock-enable that drives the core clock gate's en_i, so it sits directly upstream of the gate.
- Runs on the ungated clock and tracks fetch enable, WFI, interrupt/debug wake requests and outstanding OBI instruction/data transactions.
- Turns the core clock off only when the core is idle and the bus is quiescent.
- Restores the clock after a programmable wake delay.

Parameters:
- OUTST_W, 2, width of each outstanding-transaction counter; max count = 2^OUTST_W-1.
- WAKE_DELAY, 2, number of cycles spent in WAKE with the clock running before core_sleep_o deasserts (0 = skip WAKE).

Ports:
- clk_i  in  1  free-running (ungated) clock
- rst_i  in  1  synchronous, active-high reset
- fetch_enable_i  in  1  SoC fetch enable (level)
- wfi_i  in  1  single-cycle pulse: core retired WFI
- irq_pending_i  in  1  any enabled interrupt pending (level)
- debug_req_i  in  1  debug request (level)
- instr_req_i  in  1  OBI instruction request
- instr_gnt_i  in  1  OBI instruction grant
- instr_rvalid_i  in  1  OBI instruction response
- data_req_i  in  1  OBI data request
- data_gnt_i  in  1  OBI data grant
- data_rvalid_i  in  1  OBI data response
- clock_en_o  out  1  to clock gate en_i
- core_sleep_o  out  1  core is asleep or waking
- fetch_enable_o  out  1  sticky latched fetch enable
- instr_outst_o  out  OUTST_W  outstanding instruction transactions
- data_outst_o  out  OUTST_W  outstanding data transactions

Behaviour:
- Clock and reset: single clock clk_i. Synchronous active-high reset rst_i. All outputs are registered.
- Reset values: state=RESET_WAIT, clock_en_o=0, core_sleep_o=0, fetch_enable_o=0, both counters=0, wake counter=0.
- fetch_enable_o: set on the cycle after fetch_enable_i=1. Sticky until rst_i.
- Outstanding counters (each bus separately): +1 on req&gnt, -1 on rvalid. Simultaneous +1/-1 holds the value. Saturate at max (no wrap). rvalid at 0 holds 0 (no underflow). Counters keep operating in every state.
- wake = irq_pending_i | debug_req_i.
- idle = instr_outst=0 & data_outst=0 & !instr_req_i & !data_req_i.
- FSM transitions (evaluated each cycle, registered):
  - RESET_WAIT: fetch_enable_i=1 -> RUN.
  - RUN: wfi_i & !wake -> DRAIN. wfi_i & wake -> stay RUN.
  - DRAIN: wake -> RUN (abort). Else idle -> SLEEP. Else stay.
  - SLEEP: wake -> WAKE, loading the wake counter with WAKE_DELAY. If WAKE_DELAY=0 -> RUN directly.
  - WAKE: decrement the wake counter each cycle; at 1 -> RUN. Wake deasserting during WAKE does not abort.
- Outputs by state (registered, so they take effect in the first cycle of the state):
  - clock_en_o = 1 in RUN, DRAIN, WAKE; 0 in RESET_WAIT, SLEEP.
  - core_sleep_o = 1 in SLEEP, WAKE; 0 otherwise.
- Latency:
  - wake asserted in SLEEP -> clock_en_o=1 next cycle.
  - core_sleep_o falls WAKE_DELAY cycles after that.
  - Last idle cycle in DRAIN -> clock_en_o=0 next cycle.
- Boundary conditions:
  - wfi_i outside RUN is ignored.
  - fetch_enable_i deasserting after the latch has no effect.
  - Reset mid-SLEEP or mid-WAKE returns to RESET_WAIT with clock_en_o=0 the next cycle, and clears the counters.
  - Request granted in the same cycle DRAIN evaluates idle: idle is false, stay in DRAIN.

Test Plan:
- Reset, fetch_enable_i=0 for 5 cycles -> clock_en_o=0. Raise fetch_enable_i -> clock_en_o=1 next cycle, fetch_enable_o=1. Drop fetch_enable_i -> fetch_enable_o stays 1.
- RUN, instr_outst=2, wfi_i pulse -> DRAIN with clock_en_o=1. Two instr_rvalid_i -> counter reaches 0 -> SLEEP next cycle, clock_en_o=0, core_sleep_o=1.
- SLEEP, WAKE_DELAY=2, irq_pending_i=1 -> cycle+1: clock_en_o=1, core_sleep_o=1. cycle+3: core_sleep_o=0, state RUN.
- DRAIN with data_outst=1, debug_req_i=1 -> RUN next cycle. clock_en_o never drops.
- Counters: 4 data_req&gnt with OUTST_W=2 -> data_outst saturates at 3. Simultaneous gnt+rvalid -> unchanged. rvalid at 0 -> stays 0.
- rst_i asserted during WAKE -> next cycle state RESET_WAIT, clock_en_o=0, core_sleep_o=0, counters=0.
